fight_referee: RTL and testbench
================================

Name: fight_referee

Overview:
- Match controller that sits directly downstream of the two player blocks.
- Consumes both players' 2-bit health, runs a per-round countdown timer, and decides round winners (KO or timeout).
- Tracks round wins and declares the match result (best-of rounds).
- Drives a one-cycle round_reset pulse that restarts both player blocks at the start of every round.

Parameters:
- ROUND_TICKS, 16, round length in clk cycles; timer loads this value at round start.
- ROUNDS_TO_WIN, 2, round wins needed to take the match (1..3).
- MAX_ROUNDS, 5, hard cap on rounds played (covers repeated draws).
- END_HOLD, 4, clk cycles spent in ROUND_END before the next decision.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin match; honoured only in IDLE or MATCH_OVER
- health1  in  2  player 1 health (0..3)
- health2  in  2  player 2 health (0..3)
- round_reset  out  1  one-cycle pulse to the player blocks at each round start
- round_active  out  1  high while in FIGHT
- timer  out  $clog2(ROUND_TICKS+1)  remaining ticks in the current round
- round_winner  out  2  00 none, 01 P1, 10 P2, 11 draw; last decided round
- wins1  out  2  rounds won by P1
- wins2  out  2  rounds won by P2
- round_cnt  out  3  rounds completed
- match_over  out  1  high in MATCH_OVER
- match_winner  out  2  same encoding as round_winner; valid while match_over

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs are 0, timer=0, round_winner=00.
  - Applies immediately mid-round, with no completion of the current round.
- States: IDLE, FIGHT, ROUND_END, MATCH_OVER. All outputs are registered.
- IDLE, start=1: next cycle enters FIGHT.
  - timer=ROUND_TICKS; round_reset=1 for exactly that first FIGHT cycle.
  - wins1, wins2, round_cnt and round_winner are cleared.
- FIGHT: each cycle, in priority order:
  1. KO (health1==0 or health2==0): both 0 -> draw; health1==0 -> P2; health2==0 -> P1.
  2. Timeout (timer==1, no KO): higher health wins; equal health -> draw.
  3. Otherwise timer decrements by 1.
  - round_reset cycle: health inputs are ignored, since the players have not re-initialised yet.
- On a decision:
  - round_winner is latched.
  - The winner's wins count increments (saturates at ROUNDS_TO_WIN); a draw increments neither.
  - round_cnt increments; timer is set to 0.
  - Next state is ROUND_END.
  - KO and timeout in the same cycle count as a KO.
- ROUND_END: holds for END_HOLD cycles (internal counter), then:
  - If wins1 or wins2 == ROUNDS_TO_WIN, or round_cnt == MAX_ROUNDS: go to MATCH_OVER.
    - match_winner = player with more wins, 11 if equal.
  - Else re-enter FIGHT with the same load and round_reset pulse as from IDLE; wins are kept.
- MATCH_OVER: all outputs hold. start=1 clears the counters and enters FIGHT as from IDLE.
- start outside IDLE/MATCH_OVER: ignored.
- Health values are used as-is (0..3); no width extension is needed for comparison.

Optional Feature:
- Macro: FIGHT_REFEREE_SUDDEN_DEATH_EN.
- Defined: a timeout with equal health does not end the round.
  - timer holds at 0 and round_active stays high.
  - The round ends on the first cycle with a KO or unequal health; the higher health wins.
- Undefined: a timeout with equal health is a draw (11).

Decomposition:
- Shared package fight_pkg holds:
  - state enum
  - winner codes (WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW)
  - action codes and one-hot position constants shared with the player blocks
  - HEALTH_W=2, HEALTH_MAX=3
- One natural sub-module: round_timer.
  - Inputs: load, dec, hold-at-zero.
  - Outputs: count, last_tick flag.
  - Instantiated once.

Test Plan:
- Reset mid-FIGHT (timer=9, wins1=1) -> same cycle all outputs 0, state IDLE; round_reset stays 0.
- start, health2 drops to 0 at timer=10 -> round_winner=01, wins1=1.
  - After 4 hold cycles: FIGHT again with timer=16 and a 1-cycle round_reset.
- Two P2 KOs -> wins2=2, match_over=1, match_winner=10; later start clears wins and pulses round_reset.
- Timeout with health1=2, health2=3 -> round_winner=10. With health 1/1 and macro off -> 11, no wins change.
  - Macro on: timer stays 0 until health1=0 -> 10.
- Simultaneous health1=0, health2=0 at timer=1 -> draw (KO priority).
  - 5 consecutive draws -> match_over=1, match_winner=11, round_cnt=5.

Source files
------------

// File: rtl/fight_pkg.sv
// Shared match/player definitions: FSM states, winner codes, action and position encodings.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fight_pkg;

    localparam int HEALTH_W = 2;
    localparam logic [HEALTH_W-1:0] HEALTH_MAX = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIGHT,
        ST_ROUND_END,
        ST_MATCH_OVER
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Player-block action codes and one-hot arena positions.
    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_MOVE,
        ACT_ATTACK,
        ACT_BLOCK
    } action_t;

    localparam int POS_W = 4;
    localparam logic [POS_W-1:0] POS_LEFT_EDGE  = 4'b0001;
    localparam logic [POS_W-1:0] POS_LEFT       = 4'b0010;
    localparam logic [POS_W-1:0] POS_RIGHT      = 4'b0100;
    localparam logic [POS_W-1:0] POS_RIGHT_EDGE = 4'b1000;

    // Larger value wins; equal values are a draw. Used for health and win tallies.
    function automatic logic [1:0] higher_of(input logic [HEALTH_W-1:0] a,
                                             input logic [HEALTH_W-1:0] b);
        if (a > b)
            return WIN_P1;
        else if (b > a)
            return WIN_P2;
        else
            return WIN_DRAW;
    endfunction

    function automatic logic [1:0] ko_winner(input logic [HEALTH_W-1:0] h1,
                                             input logic [HEALTH_W-1:0] h2);
        if (h1 == '0 && h2 == '0)
            return WIN_DRAW;
        else if (h1 == '0)
            return WIN_P2;
        else
            return WIN_P1;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Per-round countdown: load to TICKS, decrement on request, clear and hold at zero.
// Latency: count updates one cycle after load/dec/zero_hold; last_tick is combinational from count.
// Backpressure: none; load beats zero_hold beats dec, and the count never wraps below zero.
module round_timer #(
    parameter int TICKS = 16,
    parameter int W     = $clog2(TICKS + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic         zero_hold,
    output logic [W-1:0] count,
    output logic         last_tick
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= W'(TICKS);
        else if (zero_hold)
            count <= '0;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign last_tick = (count == W'(1));

endmodule

// File: rtl/fight_referee.sv
// Match controller: judges rounds (KO/timeout), tallies wins, declares the best-of match winner; FIGHT_REFEREE_SUDDEN_DEATH_EN extends tied timeouts.
// Latency: all outputs registered; a decision appears the cycle after the deciding health/timer values.
// Backpressure: none; start is ignored outside IDLE/MATCH_OVER, health is ignored on the round_reset cycle.
module fight_referee
    import fight_pkg::*;
#(
    parameter int ROUND_TICKS   = 16,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int END_HOLD      = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [1:0]                         health1,
    input  logic [1:0]                         health2,
    output logic                               round_reset,
    output logic                               round_active,
    output logic [$clog2(ROUND_TICKS+1)-1:0]   timer,
    output logic [1:0]                         round_winner,
    output logic [1:0]                         wins1,
    output logic [1:0]                         wins2,
    output logic [2:0]                         round_cnt,
    output logic                               match_over,
    output logic [1:0]                         match_winner
);

    localparam int TW     = $clog2(ROUND_TICKS + 1);
    localparam int HOLD_W = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_d;
    logic                round_reset_d;
    logic [1:0]          winner_d, wins1_d, wins2_d, mwin_d;
    logic [2:0]          cnt_d;
    logic                mover_d;
    logic                t_load, t_dec, t_zero;
    logic                last_tick;
    logic                decide;
    logic [1:0]          dec_code;
    logic                ko;

    round_timer #(
        .TICKS (ROUND_TICKS),
        .W     (TW)
    ) u_round_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (t_load),
        .dec       (t_dec),
        .zero_hold (t_zero),
        .count     (timer),
        .last_tick (last_tick)
    );

    assign ko = (health1 == '0) || (health2 == '0);

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_cnt;
        round_reset_d = 1'b0;
        winner_d      = round_winner;
        wins1_d       = wins1;
        wins2_d       = wins2;
        cnt_d         = round_cnt;
        mover_d       = match_over;
        mwin_d        = match_winner;
        t_load        = 1'b0;
        t_dec         = 1'b0;
        t_zero        = 1'b0;
        decide        = 1'b0;
        dec_code      = WIN_NONE;

        case (state_q)
            ST_IDLE, ST_MATCH_OVER: begin
                if (start) begin
                    state_d       = ST_FIGHT;
                    round_reset_d = 1'b1;
                    t_load        = 1'b1;
                    winner_d      = WIN_NONE;
                    wins1_d       = '0;
                    wins2_d       = '0;
                    cnt_d         = '0;
                    mover_d       = 1'b0;
                    mwin_d        = WIN_NONE;
                end
            end

            ST_FIGHT: begin
                // Players are still re-initialising during the round_reset cycle.
                if (round_reset) begin
                    t_dec = 1'b1;
                end else if (ko) begin
                    decide   = 1'b1;
                    dec_code = ko_winner(health1, health2);
`ifdef FIGHT_REFEREE_SUDDEN_DEATH_EN
                end else if (last_tick || timer == '0) begin
                    if (health1 != health2) begin
                        decide   = 1'b1;
                        dec_code = higher_of(health1, health2);
                    end else if (last_tick) begin
                        t_dec = 1'b1;
                    end
`else
                end else if (last_tick) begin
                    decide   = 1'b1;
                    dec_code = higher_of(health1, health2);
`endif
                end else begin
                    t_dec = 1'b1;
                end

                if (decide) begin
                    winner_d = dec_code;
                    if (dec_code == WIN_P1 && wins1 != 2'(ROUNDS_TO_WIN))
                        wins1_d = wins1 + 2'd1;
                    if (dec_code == WIN_P2 && wins2 != 2'(ROUNDS_TO_WIN))
                        wins2_d = wins2 + 2'd1;
                    cnt_d   = round_cnt + 3'd1;
                    t_zero  = 1'b1;
                    hold_d  = '0;
                    state_d = ST_ROUND_END;
                end
            end

            ST_ROUND_END: begin
                if (hold_cnt == HOLD_W'(END_HOLD - 1)) begin
                    if (wins1 == 2'(ROUNDS_TO_WIN) || wins2 == 2'(ROUNDS_TO_WIN) ||
                        round_cnt == 3'(MAX_ROUNDS)) begin
                        state_d = ST_MATCH_OVER;
                        mover_d = 1'b1;
                        mwin_d  = higher_of(wins1, wins2);
                    end else begin
                        state_d       = ST_FIGHT;
                        round_reset_d = 1'b1;
                        t_load        = 1'b1;
                    end
                end else begin
                    hold_d = hold_cnt + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_cnt     <= '0;
            round_reset  <= 1'b0;
            round_active <= 1'b0;
            round_winner <= WIN_NONE;
            wins1        <= '0;
            wins2        <= '0;
            round_cnt    <= '0;
            match_over   <= 1'b0;
            match_winner <= WIN_NONE;
        end else begin
            state_q      <= state_d;
            hold_cnt     <= hold_d;
            round_reset  <= round_reset_d;
            round_active <= (state_d == ST_FIGHT);
            round_winner <= winner_d;
            wins1        <= wins1_d;
            wins2        <= wins2_d;
            round_cnt    <= cnt_d;
            match_over   <= mover_d;
            match_winner <= mwin_d;
        end
    end

endmodule

// File: tb/tb_fight_referee.sv
// Directed bench for fight_referee: reset, KO, timeout, match end, draw cap.
`timescale 1ns/1ps
module tb_fight_referee;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] health1, health2;
    logic       round_reset, round_active;
    logic [4:0] timer;
    logic [1:0] round_winner, wins1, wins2;
    logic [2:0] round_cnt;
    logic       match_over;
    logic [1:0] match_winner;

    int vecs = 0;
    int errs = 0;

    fight_referee #(
        .ROUND_TICKS   (16),
        .ROUNDS_TO_WIN (2),
        .MAX_ROUNDS    (5),
        .END_HOLD      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .health1      (health1),
        .health2      (health2),
        .round_reset  (round_reset),
        .round_active (round_active),
        .timer        (timer),
        .round_winner (round_winner),
        .wins1        (wins1),
        .wins2        (wins2),
        .round_cnt    (round_cnt),
        .match_over   (match_over),
        .match_winner (match_winner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [17:0] all_out;
        rst = 1'b1; start = 1'b0; health1 = 2'd3; health2 = 2'd3;
        tick(2);
        all_out = {round_reset, round_active, timer, round_winner, wins1, wins2, round_cnt, match_over, match_winner};
        vecs++; if (all_out !== 18'd0) begin errs++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        rst = 1'b0;
        tick(3);
        all_out = {round_reset, round_active, timer, round_winner, wins1, wins2, round_cnt, match_over, match_winner};
        vecs++; if (all_out !== 18'd0) begin errs++; $display("FAIL idle_hold: got %h want 0", all_out); end
    endtask

    task automatic test_ko_p1();
        pulse_start();
        vecs++; if ({round_reset, round_active, timer} !== {1'b1, 1'b1, 5'd16}) begin errs++;
            $display("FAIL start_load: got rr=%b ra=%b t=%0d want 1 1 16", round_reset, round_active, timer); end
        tick(6);
        vecs++; if ({round_reset, timer} !== {1'b0, 5'd10}) begin errs++;
            $display("FAIL countdown: got rr=%b t=%0d want 0 10", round_reset, timer); end
        health2 = 2'd0;
        tick();
        vecs++; if ({round_winner, wins1, wins2, round_cnt, timer, round_active} !== {2'b01, 2'd1, 2'd0, 3'd1, 5'd0, 1'b0}) begin errs++;
            $display("FAIL ko_p1: got w=%b w1=%0d w2=%0d rc=%0d t=%0d ra=%b want 01 1 0 1 0 0",
                     round_winner, wins1, wins2, round_cnt, timer, round_active); end
        health2 = 2'd3;
        tick(3);
        vecs++; if ({round_reset, round_active} !== 2'b00) begin errs++;
            $display("FAIL end_hold: got rr=%b ra=%b want 0 0", round_reset, round_active); end
        tick();
        vecs++; if ({round_reset, timer, wins1, round_cnt, round_winner} !== {1'b1, 5'd16, 2'd1, 3'd1, 2'b01}) begin errs++;
            $display("FAIL next_round: got rr=%b t=%0d w1=%0d rc=%0d w=%b want 1 16 1 1 01",
                     round_reset, timer, wins1, round_cnt, round_winner); end
        tick();
        vecs++; if ({round_reset, timer} !== {1'b0, 5'd15}) begin errs++;
            $display("FAIL rr_one_cycle: got rr=%b t=%0d want 0 15", round_reset, timer); end
    endtask

    task automatic test_reset_mid();
        logic [17:0] all_out;
        tick(6);
        vecs++; if ({timer, wins1} !== {5'd9, 2'd1}) begin errs++;
            $display("FAIL mid_setup: got t=%0d w1=%0d want 9 1", timer, wins1); end
        rst = 1'b1;
        #1;
        all_out = {round_reset, round_active, timer, round_winner, wins1, wins2, round_cnt, match_over, match_winner};
        vecs++; if (all_out !== 18'd0) begin errs++; $display("FAIL reset_async: got %h want 0", all_out); end
        tick();
        all_out = {round_reset, round_active, timer, round_winner, wins1, wins2, round_cnt, match_over, match_winner};
        vecs++; if (all_out !== 18'd0) begin errs++; $display("FAIL reset_held: got %h want 0", all_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_p2_match();
        pulse_start();
        health1 = 2'd0;
        tick();
        vecs++; if ({timer, round_winner} !== {5'd15, 2'b00}) begin errs++;
            $display("FAIL rr_ignores_health: got t=%0d w=%b want 15 00", timer, round_winner); end
        tick();
        vecs++; if ({round_winner, wins2, round_cnt} !== {2'b10, 2'd1, 3'd1}) begin errs++;
            $display("FAIL ko_p2_r1: got w=%b w2=%0d rc=%0d want 10 1 1", round_winner, wins2, round_cnt); end
        health1 = 2'd3;
        tick(4);
        vecs++; if (round_reset !== 1'b1) begin errs++; $display("FAIL p2_r2_start: got rr=%b want 1", round_reset); end
        health1 = 2'd0;
        tick(2);
        vecs++; if ({round_winner, wins2, round_cnt, match_over} !== {2'b10, 2'd2, 3'd2, 1'b0}) begin errs++;
            $display("FAIL ko_p2_r2: got w=%b w2=%0d rc=%0d mo=%b want 10 2 2 0", round_winner, wins2, round_cnt, match_over); end
        tick(4);
        vecs++; if ({match_over, match_winner, round_active} !== {1'b1, 2'b10, 1'b0}) begin errs++;
            $display("FAIL match_p2: got mo=%b mw=%b ra=%b want 1 10 0", match_over, match_winner, round_active); end
        health1 = 2'd3;
        tick(3);
        vecs++; if ({match_over, wins2, round_cnt, timer, round_reset} !== {1'b1, 2'd2, 3'd2, 5'd0, 1'b0}) begin errs++;
            $display("FAIL match_hold: got mo=%b w2=%0d rc=%0d t=%0d rr=%b want 1 2 2 0 0",
                     match_over, wins2, round_cnt, timer, round_reset); end
        pulse_start();
        vecs++; if ({round_reset, wins2, round_cnt, match_over, match_winner, round_winner, timer} !==
                    {1'b1, 2'd0, 3'd0, 1'b0, 2'b00, 2'b00, 5'd16}) begin errs++;
            $display("FAIL restart: got rr=%b w2=%0d rc=%0d mo=%b mw=%b w=%b t=%0d want 1 0 0 0 00 00 16",
                     round_reset, wins2, round_cnt, match_over, match_winner, round_winner, timer); end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        vecs++; if ({round_reset, timer} !== {1'b0, 5'd14}) begin errs++;
            $display("FAIL start_ignored: got rr=%b t=%0d want 0 14", round_reset, timer); end
    endtask

    task automatic test_timeout();
        pulse_reset();
        health1 = 2'd2; health2 = 2'd3;
        pulse_start();
        tick(15);
        vecs++; if ({timer, round_winner} !== {5'd1, 2'b00}) begin errs++;
            $display("FAIL timer_last: got t=%0d w=%b want 1 00", timer, round_winner); end
        tick();
        vecs++; if ({round_winner, wins2, round_cnt, timer} !== {2'b10, 2'd1, 3'd1, 5'd0}) begin errs++;
            $display("FAIL timeout_p2: got w=%b w2=%0d rc=%0d t=%0d want 10 1 1 0", round_winner, wins2, round_cnt, timer); end
        health1 = 2'd1; health2 = 2'd1;
        tick(4);
        tick(15);
        tick();
`ifdef FIGHT_REFEREE_SUDDEN_DEATH_EN
        vecs++; if ({timer, round_active, round_winner, round_cnt} !== {5'd0, 1'b1, 2'b10, 3'd1}) begin errs++;
            $display("FAIL sudden_death_enter: got t=%0d ra=%b w=%b rc=%0d want 0 1 10 1", timer, round_active, round_winner, round_cnt); end
        tick(3);
        vecs++; if ({timer, round_active} !== {5'd0, 1'b1}) begin errs++;
            $display("FAIL sudden_death_hold: got t=%0d ra=%b want 0 1", timer, round_active); end
        health1 = 2'd0;
        tick();
        vecs++; if ({round_winner, wins2, round_cnt, round_active} !== {2'b10, 2'd2, 3'd2, 1'b0}) begin errs++;
            $display("FAIL sudden_death_ko: got w=%b w2=%0d rc=%0d ra=%b want 10 2 2 0", round_winner, wins2, round_cnt, round_active); end
`else
        vecs++; if ({round_winner, wins1, wins2, round_cnt, round_active} !== {2'b11, 2'd0, 2'd1, 3'd2, 1'b0}) begin errs++;
            $display("FAIL timeout_draw: got w=%b w1=%0d w2=%0d rc=%0d ra=%b want 11 0 1 2 0",
                     round_winner, wins1, wins2, round_cnt, round_active); end
`endif
    endtask

    task automatic test_draws();
        pulse_reset();
        health1 = 2'd3; health2 = 2'd3;
        pulse_start();
        tick(15);
        health1 = 2'd0; health2 = 2'd0;
        tick();
        vecs++; if ({round_winner, round_cnt, wins1, wins2} !== {2'b11, 3'd1, 2'd0, 2'd0}) begin errs++;
            $display("FAIL ko_beats_timeout: got w=%b rc=%0d w1=%0d w2=%0d want 11 1 0 0", round_winner, round_cnt, wins1, wins2); end
        for (int r = 2; r <= 5; r++) begin
            tick(4);
            vecs++; if (round_reset !== 1'b1) begin errs++; $display("FAIL draw_round_start: round %0d got rr=%b want 1", r, round_reset); end
            tick(2);
            vecs++; if ({round_cnt, round_winner} !== {3'(r), 2'b11}) begin errs++;
                $display("FAIL draw_round: got rc=%0d w=%b want %0d 11", round_cnt, round_winner, r); end
        end
        tick(4);
        vecs++; if ({match_over, match_winner, round_cnt, wins1, wins2} !== {1'b1, 2'b11, 3'd5, 2'd0, 2'd0}) begin errs++;
            $display("FAIL draw_cap: got mo=%b mw=%b rc=%0d w1=%0d w2=%0d want 1 11 5 0 0",
                     match_over, match_winner, round_cnt, wins1, wins2); end
    endtask

    initial begin
        test_reset();
        test_ko_p1();
        test_reset_mid();
        test_p2_match();
        test_timeout();
        test_draws();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
